// File: rtl/button_conditioner.sv
// button_conditioner
//
// Input stage between the board pins (buttons and switches) and the game
// logic. Every channel is synchronised to CLK_40M with two flops, then
// debounced: a new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples that differ from the current level. Any sample that
// matches the current level restarts the count.
//
// Ports:
//   CLK_40M        in   1           system clock
//   RESET          in   1           asynchronous, active-high reset
//   RAW_IN         in   NUM_INPUTS  raw pin levels, 1 = pressed/on
//   LEVEL_OUT      out  NUM_INPUTS  debounced level
//   PRESS_PULSE    out  NUM_INPUTS  one-cycle pulse on an accepted 0->1
//   RELEASE_PULSE  out  NUM_INPUTS  one-cycle pulse on an accepted 1->0
//
// Optional feature, macro BTN_AUTOREPEAT_EN: channels with REPEAT_MASK[i]=1
// re-fire PRESS_PULSE REPEAT_DELAY cycles after the press pulse and then
// every REPEAT_PERIOD cycles while the level stays high. With the macro
// undefined the repeat parameters produce no logic.

module button_conditioner #(
  parameter int                    NUM_INPUTS      = 7,
  parameter int                    DEBOUNCE_CYCLES = 400000,
  parameter int                    REPEAT_DELAY    = 16000000,
  parameter int                    REPEAT_PERIOD   = 4000000,
  parameter logic [NUM_INPUTS-1:0] REPEAT_MASK     = 7'b0000011
) (
  input  logic                  CLK_40M,
  input  logic                  RESET,
  input  logic [NUM_INPUTS-1:0] RAW_IN,
  output logic [NUM_INPUTS-1:0] LEVEL_OUT,
  output logic [NUM_INPUTS-1:0] PRESS_PULSE,
  output logic [NUM_INPUTS-1:0] RELEASE_PULSE
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
  logic [NUM_INPUTS-1:0] level_q, level_d;
  logic [NUM_INPUTS-1:0] press_q, press_d;
  logic [NUM_INPUTS-1:0] release_q, release_d;
  logic [CNT_W-1:0]      debCnt_q [NUM_INPUTS];
  logic [CNT_W-1:0]      debCnt_d [NUM_INPUTS];

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX) + 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]      repCnt_q [NUM_INPUTS];
  logic [REP_W-1:0]      repCnt_d [NUM_INPUTS];
  // Set while waiting for the first (longer) repeat interval.
  logic [NUM_INPUTS-1:0] repFirst_q, repFirst_d;
`else
  // Ties off the repeat settings so the default build carries them unused.
  logic unusedRepeatCfg;
  assign unusedRepeatCfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0) ^ (^REPEAT_MASK);
`endif

  // Debounce decision per channel. A match with the current level clears the
  // counter; only an unbroken run of DEBOUNCE_CYCLES differing samples flips
  // the level, and the flip also loads the matching one-cycle pulse.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      debCnt_d[i] = debCnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        debCnt_d[i] = '0;
      end else if (debCnt_q[i] == CNT_LAST) begin
        debCnt_d[i]  = '0;
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        debCnt_d[i] = debCnt_q[i] + CNT_W'(1);
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timer runs only while the accepted level stays high. The cycle
    // of an accepted release is checked first so no repeat can land on or
    // after it.
    for (int i = 0; i < NUM_INPUTS; i++) begin
      repCnt_d[i]   = repCnt_q[i];
      repFirst_d[i] = repFirst_q[i];
      if (!REPEAT_MASK[i] || !level_d[i]) begin
        repCnt_d[i]   = '0;
        repFirst_d[i] = 1'b0;
      end else if (!level_q[i]) begin
        repCnt_d[i]   = '0;
        repFirst_d[i] = 1'b1;
      end else if (repCnt_q[i] == (repFirst_q[i] ? DELAY_LAST : PERIOD_LAST)) begin
        press_d[i]    = 1'b1;
        repCnt_d[i]   = '0;
        repFirst_d[i] = 1'b0;
      end else begin
        repCnt_d[i] = repCnt_q[i] + REP_W'(1);
      end
    end
`endif
  end

  // All state, including both synchroniser stages, clears asynchronously.
  always_ff @(posedge CLK_40M or posedge RESET) begin
    if (RESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        debCnt_q[i] <= '0;
      end
`ifdef BTN_AUTOREPEAT_EN
      repFirst_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        repCnt_q[i] <= '0;
      end
`endif
    end else begin
      sync1_q   <= RAW_IN;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        debCnt_q[i] <= debCnt_d[i];
      end
`ifdef BTN_AUTOREPEAT_EN
      repFirst_q <= repFirst_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        repCnt_q[i] <= repCnt_d[i];
      end
`endif
    end
  end

  assign LEVEL_OUT     = level_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage between the board pins (BTN_LEFT, BTN_RIGHT, BTN_A, BTN_B, SW_RESET, SW_PAUSE, SW_IGNORE_DEATH) and the top-level game logic.
- Synchronises each raw mechanical input to CLK_40M and debounces it with a per-channel stability counter.
- Provides clean levels and single-cycle press/release pulses to the game controller.
- Uses one channel per input so buttons and switches share the same logic.

Parameters:
- NUM_INPUTS, 7, number of independent channels.
- DEBOUNCE_CYCLES, 400000, consecutive stable cycles required before a level change is accepted (10 ms at 40 MHz); legal range >= 1.
- REPEAT_DELAY, 16000000, cycles from accepted press to first repeat pulse (0.4 s); used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 4000000, cycles between subsequent repeat pulses (0.1 s); used only with BTN_AUTOREPEAT_EN.
- REPEAT_MASK, 7'b0000011, bit i = 1 enables auto-repeat on channel i; used only with BTN_AUTOREPEAT_EN.

Ports:
- CLK_40M  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- RAW_IN  input  NUM_INPUTS  unsynchronised pin levels; 1 = pressed/on.
- LEVEL_OUT  output  NUM_INPUTS  debounced level.
- PRESS_PULSE  output  NUM_INPUTS  one-cycle pulse on an accepted 0->1 change (and on repeats if enabled).
- RELEASE_PULSE  output  NUM_INPUTS  one-cycle pulse on an accepted 1->0 change.

Behaviour:
- Reset (async, RESET high): all synchroniser flops, LEVEL_OUT, PRESS_PULSE, RELEASE_PULSE and counters clear to 0. Outputs stay 0 while RESET is high.
- Release: deassertion is taken on any edge. A pin held at 1 through reset is treated as a fresh press; it appears DEBOUNCE_CYCLES+1 edges after release.
- Per channel, a two-flop synchroniser: sync1 <= RAW_IN[i], sync2 <= sync1. There is no other logic on sync1.
- Counter width: clog2(DEBOUNCE_CYCLES)+1 bits, derived internally as a localparam.
- Debounce rule on each edge:
  - sync2 == LEVEL_OUT[i]: counter <= 0.
  - sync2 != LEVEL_OUT[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != LEVEL_OUT[i] and counter == DEBOUNCE_CYCLES-1: LEVEL_OUT[i] <= sync2, counter <= 0, and the matching pulse is set.
- Any bounce back to the old level restarts the count from 0. There is no partial credit.
- Latency: if RAW_IN[i] is first sampled at its new value on edge k and held, LEVEL_OUT[i] changes on edge k+DEBOUNCE_CYCLES+1. PRESS_PULSE or RELEASE_PULSE is high for exactly the cycle following that same edge.
- Pulses are registered and self-clearing. PRESS_PULSE[i] and RELEASE_PULSE[i] are never high together.
- Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Counters saturate by construction and never wrap, since they are cleared at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel with REPEAT_MASK[i] = 1 has a repeat counter, cleared on its accepted press.
  - While LEVEL_OUT[i] stays 1, PRESS_PULSE[i] re-fires one cycle after REPEAT_DELAY cycles have elapsed since the press pulse, then every REPEAT_PERIOD cycles.
  - An accepted release or RESET clears the repeat counter immediately; no repeat pulse may follow a release.
  - Masked-off channels behave as if the macro were undefined.
- Undefined: exactly one PRESS_PULSE per accepted press; repeat counters, REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK generate no logic.

Test Plan:
1. Basic press: DEBOUNCE_CYCLES=4, RAW_IN[0] 0->1 sampled at edge 10 and held -> LEVEL_OUT[0]=1 after edge 15; PRESS_PULSE[0]=1 only in the cycle after edge 15; RELEASE_PULSE=0 throughout.
2. Bounce restart: DEBOUNCE_CYCLES=4, RAW_IN[1] goes 1 for 3 cycles, 0 for 1 cycle, then 1 steady -> no pulse during the bounce; LEVEL_OUT[1] rises exactly 5 edges after the final 0->1 sample.
3. Release and simultaneity: channels 0 and 2 held at 1, both dropped to 0 on the same edge -> both RELEASE_PULSE bits high in the same single cycle; channel 1 is unaffected.
4. Reset mid-count: RESET asserted asynchronously while counter=2 with RAW_IN=1 -> outputs go to 0 without waiting for a clock edge; after release with RAW_IN still 1, PRESS_PULSE fires DEBOUNCE_CYCLES+1 edges after the first post-reset sample.
5. Auto-repeat (macro defined): DEBOUNCE_CYCLES=2, REPEAT_DELAY=8, REPEAT_PERIOD=3, REPEAT_MASK=1 on channel 0, held 20 cycles -> pulses at press, press+8, press+11, press+14, press+17; channel 1 held gives one pulse only.
6. Macro undefined, same stimulus as scenario 5 -> exactly one PRESS_PULSE[0] per press.
